// File: rtl/mc_pin_stage.sv
// Memory pin register stage: registers all pad-facing signals and arbitrates bus
// ownership with an external master via mc_br/mc_bg, parking pins idle while granted.
module mc_pin_stage #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 24,
  parameter int unsigned NCS  = 8,
  parameter int unsigned TURN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mc_br,
  output logic                 mc_bg,
  input  logic                 ctrl_idle,
  output logic                 bus_avail,
  input  logic [AW-1:0]        mc_addr_d,
  output logic [AW-1:0]        mc_addr,
  input  logic [DW-1:0]        mc_data_od,
  input  logic [DW/8-1:0]      mc_dp_od,
  output logic [DW-1:0]        mc_data_o,
  output logic [DW/8-1:0]      mc_dp_o,
  input  logic                 data_oe,
  output logic                 mc_data_oe,
  output logic                 mc_c_oe,
  input  logic                 oe_,
  input  logic                 we_,
  input  logic                 ras_,
  input  logic                 cas_,
  output logic                 mc_oe_,
  output logic                 mc_we_,
  output logic                 mc_ras_,
  output logic                 mc_cas_,
  input  logic                 cs_en,
  input  logic                 rfr_ack,
  input  logic                 susp_sel,
  input  logic                 lmr_sel,
  input  logic [NCS-1:0]       cs_need_rfr,
  input  logic [NCS-1:0]       spec_req_cs,
  input  logic [NCS-1:0]       cs,
  output logic [NCS-1:0]       mc_cs_,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [DW/8-1:0]      wb_sel_i,
  input  logic                 wb_cycle,
  input  logic                 wr_cycle,
  output logic [DW/8-1:0]      mc_dqm,
  input  logic [DW-1:0]        mc_data_i,
  input  logic [DW/8-1:0]      mc_dp_i,
  output logic [DW+DW/8-1:0]   mc_data_ir,
  input  logic                 mc_ack,
  output logic                 mc_ack_r
);

  localparam int unsigned BW = DW / 8;
  localparam logic [3:0] TurnLd = 4'(TURN);

  typedef enum logic [1:0] {StOwn, StRelease, StGrant, StReclaim} state_e;

  state_e         state;
  logic [3:0]     tc;
  logic           br_meta, br_s;
  logic           own;
  logic [BW-1:0]  sel_r, sel_r2;
  logic [NCS-1:0] cs_sel;
  logic [BW-1:0]  dqm_d;

  assign own       = (state == StOwn);
  assign bus_avail = own;

  // mc_br comes from another clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_meta <= 1'b0;
      br_s    <= 1'b0;
    end else begin
      br_meta <= mc_br;
      br_s    <= br_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StOwn;
      tc    <= 4'd0;
      mc_bg <= 1'b0;
    end else begin
      unique case (state)
        StOwn: begin
          if (br_s && ctrl_idle) begin
            state <= StRelease;
            tc    <= TurnLd;
          end
        end
        StRelease: begin
          if (tc != 4'd0) begin
            tc <= tc - 4'd1;
          end else begin
            state <= StGrant;
            mc_bg <= 1'b1;
          end
        end
        StGrant: begin
          if (!br_s) begin
            state <= StReclaim;
            mc_bg <= 1'b0;
            tc    <= TurnLd;
          end
        end
        StReclaim: begin
          // A fresh request is only looked at once back in StOwn
          if (tc != 4'd0) tc <= tc - 4'd1;
          else            state <= StOwn;
        end
        default: state <= StOwn;
      endcase
    end
  end

  always_comb begin
    cs_sel = cs;
    if (rfr_ack || susp_sel) cs_sel = cs_need_rfr;
    else if (lmr_sel)        cs_sel = spec_req_cs;
  end

  always_comb begin
    dqm_d = '1;
    if (susp_sel || !own)          dqm_d = '1;
    else if (data_oe)              dqm_d = ~sel_r2;
    else if (wb_cycle && !wr_cycle) dqm_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r  <= '0;
      sel_r2 <= '0;
    end else begin
      if (wb_cyc_i && wb_stb_i) sel_r <= wb_sel_i;
      sel_r2 <= sel_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_addr    <= '0;
      mc_data_o  <= '0;
      mc_dp_o    <= '0;
      mc_data_ir <= '0;
      mc_ack_r   <= 1'b0;
      mc_c_oe    <= 1'b1;
      mc_data_oe <= 1'b0;
      mc_cs_     <= '1;
      mc_oe_     <= 1'b1;
      mc_we_     <= 1'b1;
      mc_ras_    <= 1'b1;
      mc_cas_    <= 1'b1;
      mc_dqm     <= '1;
    end else begin
      mc_addr    <= mc_addr_d;
      mc_data_o  <= mc_data_od;
      mc_dp_o    <= mc_dp_od;
      mc_data_ir <= {mc_dp_i, mc_data_i};
      mc_ack_r   <= mc_ack;
      mc_c_oe    <= own;
      mc_data_oe <= own & data_oe & ~susp_sel;
      mc_cs_     <= own ? ~({NCS{cs_en}} & cs_sel) : '1;
      mc_oe_     <= oe_ | susp_sel | ~own;
      mc_we_     <= we_ | ~own;
      mc_ras_    <= ras_ | ~own;
      mc_cas_    <= cas_ | ~own;
      mc_dqm     <= dqm_d;
    end
  end

endmodule

// File: tb/tb_mc_pin_stage.sv
// Scoreboard bench for mc_pin_stage: default-width instance with TURN=2 plus a
// 64-bit/4-CS instance for the width-generic data path.
module tb_mc_pin_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared scalar stimulus
  logic mc_br = 0, ctrl_idle = 1, data_oe = 0;
  logic oe_ = 1, we_ = 1, ras_ = 1, cas_ = 1;
  logic cs_en = 0, rfr_ack = 0, susp_sel = 0, lmr_sel = 0;
  logic wb_cyc_i = 0, wb_stb_i = 0, wb_cycle = 0, wr_cycle = 0, mc_ack = 0;

  // Narrow instance (DW=32, AW=24, NCS=8)
  logic [23:0] addr_d = '0;
  logic [31:0] data_od = '0, data_i = '0;
  logic [3:0]  dp_od = '0, dp_i = '0, wb_sel = '0;
  logic [7:0]  cs_need_rfr = '0, spec_req_cs = '0, cs = '0;
  logic        mc_bg, bus_avail, mc_data_oe, mc_c_oe, mc_oe_, mc_we_, mc_ras_, mc_cas_, mc_ack_r;
  logic [23:0] mc_addr;
  logic [31:0] mc_data_o;
  logic [3:0]  mc_dp_o, mc_dqm;
  logic [7:0]  mc_cs_;
  logic [35:0] mc_data_ir;

  mc_pin_stage #(.DW(32), .AW(24), .NCS(8), .TURN(2)) dut (
    .clk(clk), .rst(rst), .mc_br(mc_br), .mc_bg(mc_bg), .ctrl_idle(ctrl_idle),
    .bus_avail(bus_avail), .mc_addr_d(addr_d), .mc_addr(mc_addr), .mc_data_od(data_od),
    .mc_dp_od(dp_od), .mc_data_o(mc_data_o), .mc_dp_o(mc_dp_o), .data_oe(data_oe),
    .mc_data_oe(mc_data_oe), .mc_c_oe(mc_c_oe), .oe_(oe_), .we_(we_), .ras_(ras_),
    .cas_(cas_), .mc_oe_(mc_oe_), .mc_we_(mc_we_), .mc_ras_(mc_ras_), .mc_cas_(mc_cas_),
    .cs_en(cs_en), .rfr_ack(rfr_ack), .susp_sel(susp_sel), .lmr_sel(lmr_sel),
    .cs_need_rfr(cs_need_rfr), .spec_req_cs(spec_req_cs), .cs(cs), .mc_cs_(mc_cs_),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_sel_i(wb_sel), .wb_cycle(wb_cycle),
    .wr_cycle(wr_cycle), .mc_dqm(mc_dqm), .mc_data_i(data_i), .mc_dp_i(dp_i),
    .mc_data_ir(mc_data_ir), .mc_ack(mc_ack), .mc_ack_r(mc_ack_r)
  );

  // Wide instance (DW=64, AW=28, NCS=4)
  logic [27:0] w_addr_d = '0;
  logic [63:0] w_data_od = '0, w_data_i = '0;
  logic [7:0]  w_dp_od = '0, w_dp_i = '0, w_wb_sel = '0;
  logic [3:0]  w_cs = '0;
  logic        w_bg, w_bus_avail, w_data_oe, w_c_oe, w_oe_, w_we_, w_ras_, w_cas_, w_ack_r;
  logic [27:0] w_addr;
  logic [63:0] w_data_o;
  logic [7:0]  w_dp_o, w_dqm;
  logic [3:0]  w_cs_;
  logic [71:0] w_data_ir;

  mc_pin_stage #(.DW(64), .AW(28), .NCS(4), .TURN(1)) dut_w (
    .clk(clk), .rst(rst), .mc_br(1'b0), .mc_bg(w_bg), .ctrl_idle(ctrl_idle),
    .bus_avail(w_bus_avail), .mc_addr_d(w_addr_d), .mc_addr(w_addr), .mc_data_od(w_data_od),
    .mc_dp_od(w_dp_od), .mc_data_o(w_data_o), .mc_dp_o(w_dp_o), .data_oe(data_oe),
    .mc_data_oe(w_data_oe), .mc_c_oe(w_c_oe), .oe_(oe_), .we_(we_), .ras_(ras_),
    .cas_(cas_), .mc_oe_(w_oe_), .mc_we_(w_we_), .mc_ras_(w_ras_), .mc_cas_(w_cas_),
    .cs_en(cs_en), .rfr_ack(rfr_ack), .susp_sel(susp_sel), .lmr_sel(lmr_sel),
    .cs_need_rfr(w_cs), .spec_req_cs(w_cs), .cs(w_cs), .mc_cs_(w_cs_),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_sel_i(w_wb_sel), .wb_cycle(wb_cycle),
    .wr_cycle(wr_cycle), .mc_dqm(w_dqm), .mc_data_i(w_data_i), .mc_dp_i(w_dp_i),
    .mc_data_ir(w_data_ir), .mc_ack(mc_ack), .mc_ack_r(w_ack_r)
  );

  typedef enum int {SBg, SAvail, SCs, SDqm, SCoe, SDoe, SOe, SAddr, SData, SAck, SIr,
                    SWData, SWIrDp} sig_e;
  typedef struct {
    int           cyc;
    sig_e         sig;
    logic [127:0] val;
    string        name;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [127:0] get_sig(input sig_e s);
    case (s)
      SBg:     return 128'(mc_bg);
      SAvail:  return 128'(bus_avail);
      SCs:     return 128'(mc_cs_);
      SDqm:    return 128'(mc_dqm);
      SCoe:    return 128'(mc_c_oe);
      SDoe:    return 128'(mc_data_oe);
      SOe:     return 128'(mc_oe_);
      SAddr:   return 128'(mc_addr);
      SData:   return 128'(mc_data_o);
      SAck:    return 128'(mc_ack_r);
      SIr:     return 128'(mc_data_ir);
      SWData:  return 128'(w_data_o);
      SWIrDp:  return 128'(w_data_ir[71:64]);
      default: return '0;
    endcase
  endfunction

  // Expect signal s to equal v at the negedge after k more rising edges
  task automatic expect_at(input int k, input sig_e s, input logic [127:0] v, input string n);
    exp_t e;
    e.cyc = cyc + k;
    e.sig = s;
    e.val = v;
    e.name = n;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_checks++;
        if (get_sig(sb[i].sig) !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h", sb[i].name, cyc,
                   get_sig(sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s missed at cyc=%0d required=%0h", sb[i].name, sb[i].cyc, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values while rst is held
    tick();
    expect_at(0, SBg, 0, "rst_bg");
    expect_at(0, SAvail, 1, "rst_avail");
    expect_at(0, SCs, 128'hFF, "rst_cs");
    expect_at(0, SDqm, 128'hF, "rst_dqm");
    expect_at(0, SCoe, 1, "rst_c_oe");
    expect_at(0, SDoe, 0, "rst_data_oe");
    expect_at(0, SOe, 1, "rst_oe");
    expect_at(0, SAddr, 0, "rst_addr");
    expect_at(0, SAck, 0, "rst_ack");
    expect_at(0, SWData, 0, "rst_w_data");
    tick();
    rst = 0;
    tick();

    // One-clock pin latency, narrow and wide
    addr_d = 24'h123456; data_od = 32'hCAFEF00D; mc_ack = 1;
    data_i = 32'h89ABCDEF; dp_i = 4'h9;
    w_data_od = 64'hDEADBEEF_01234567; w_dp_i = 8'hA5;
    expect_at(0, SAddr, 0, "addr_pre");
    expect_at(1, SAddr, 128'h123456, "addr_lat");
    expect_at(1, SData, 128'hCAFEF00D, "data_lat");
    expect_at(1, SAck, 1, "ack_lat");
    expect_at(1, SIr, 128'h9_89ABCDEF, "data_ir");
    expect_at(1, SWData, 128'hDEADBEEF_01234567, "w_data");
    expect_at(1, SWIrDp, 128'hA5, "w_ir_dp");
    tick();
    mc_ack = 0;

    // Chip-select priority
    cs_en = 1; rfr_ack = 1; cs_need_rfr = 8'h04; cs = 8'h01;
    expect_at(1, SCs, 128'hFB, "cs_rfr");
    tick();
    rfr_ack = 0; lmr_sel = 1; spec_req_cs = 8'h80;
    expect_at(1, SCs, 128'h7F, "cs_lmr");
    tick();
    cs_en = 0;
    expect_at(1, SCs, 128'hFF, "cs_dis");
    tick();
    cs_en = 1; lmr_sel = 0;
    expect_at(1, SCs, 128'hFE, "cs_plain");
    tick();

    // Byte mask path
    wb_cyc_i = 1; wb_stb_i = 1; wb_sel = 4'b0011;
    tick();
    wb_cyc_i = 0; wb_stb_i = 0; wb_sel = 4'b1111;
    tick();
    data_oe = 1;
    expect_at(1, SDqm, 128'hC, "dqm_write");
    expect_at(1, SDoe, 1, "data_oe");
    tick();
    data_oe = 0; wb_cycle = 1; wr_cycle = 0; oe_ = 0;
    expect_at(1, SDqm, 128'h0, "dqm_read");
    expect_at(1, SOe, 0, "oe_read");
    tick();
    susp_sel = 1;
    expect_at(1, SDqm, 128'hF, "dqm_susp");
    expect_at(1, SOe, 1, "oe_susp");
    tick();
    susp_sel = 0; wb_cycle = 0; oe_ = 1; cs_need_rfr = 8'h00;
    tick();

    // Grant with TURN=2
    mc_br = 1;
    expect_at(2, SAvail, 1, "g_avail_e1");
    expect_at(3, SAvail, 0, "g_avail_e2");
    expect_at(3, SCoe, 1, "g_c_oe_e2");
    expect_at(4, SCoe, 0, "g_c_oe_e3");
    expect_at(3, SCs, 128'hFE, "g_cs_e2");
    expect_at(4, SCs, 128'hFF, "g_cs_e3");
    expect_at(4, SDqm, 128'hF, "g_dqm");
    expect_at(5, SBg, 0, "g_bg_e4");
    expect_at(6, SBg, 1, "g_bg_e5");
    repeat (7) tick();
    mc_br = 0;
    expect_at(2, SBg, 1, "r_bg_hold");
    expect_at(3, SBg, 0, "r_bg_drop");
    expect_at(5, SAvail, 0, "r_avail_pre");
    expect_at(6, SAvail, 1, "r_avail");
    expect_at(6, SCoe, 0, "r_c_oe_pre");
    expect_at(7, SCoe, 1, "r_c_oe");
    expect_at(7, SCs, 128'hFE, "r_cs");
    repeat (8) tick();

    // Deferred grant while the core is busy
    ctrl_idle = 0; mc_br = 1;
    for (int k = 1; k <= 10; k++) begin
      expect_at(k, SBg, 0, "def_bg");
      expect_at(k, SAvail, 1, "def_avail");
    end
    repeat (10) tick();
    ctrl_idle = 1;
    expect_at(0, SAvail, 1, "def_own");
    expect_at(1, SAvail, 0, "def_release");
    expect_at(3, SBg, 0, "def_bg_pre");
    expect_at(4, SBg, 1, "def_bg");
    repeat (5) tick();

    // Reset mid-grant acts immediately
    rst = 1; mc_br = 0;
    expect_at(0, SBg, 0, "rstg_bg");
    expect_at(0, SCs, 128'hFF, "rstg_cs");
    expect_at(0, SAvail, 1, "rstg_avail");
    expect_at(0, SCoe, 1, "rstg_c_oe");
    tick();
    rst = 0;
    for (int k = 1; k <= 8; k++) begin
      expect_at(k, SBg, 0, "post_rst_bg");
      expect_at(k, SAvail, 1, "post_rst_avail");
    end
    repeat (9) tick();

    for (int t = 0; t < 50 && sb.size() != 0; t++) tick();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
